brick_hit_ctrl: RTL and testbench
=================================

BRICK_HIT_CTRL -- requirements
Module: brick_hit_ctrl

Interface
REQ-001 Parameter BRICK_W, default 80: brick width in pixels.
REQ-002 Parameter BRICK_H, default 20: brick height in pixels.
REQ-003 Parameter BRICK_TOP, default 40: first brick-row top line.
REQ-004 Parameter COLS, default 8: bricks per row; ROWS = 3 fixed; 24 bricks total.
REQ-005 clk  input  1  single system clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 pos_valid  input  1  one-cycle strobe; bv_pos/bh_pos valid this cycle.
REQ-008 bv_pos  input  11  ball vertical pixel position.
REQ-009 bh_pos  input  11  ball horizontal pixel position.
REQ-010 new_level  input  1  one-cycle pulse; restores all bricks.
REQ-011 arr  output  24  brick-alive map; bit i = brick index i (row*COLS + col); 1 = present.
REQ-012 hit  output  1  one-cycle pulse; a brick was destroyed.
REQ-013 hit_idx  output  5  index of the last destroyed brick; held until the next hit.
REQ-014 busy  output  1  high while the FSM is not in IDLE.
REQ-015 score  output  10  count of destroyed bricks since reset.
REQ-016 all_clear  output  1  high when arr == 0.

Function
REQ-017 FSM states: IDLE, LOCATE, CHECK, CLEAR.
REQ-018 IDLE: pos_valid=1 -> capture bv_pos/bh_pos into registers -> LOCATE.
REQ-019 LOCATE: in_field = BRICK_TOP <= bv < BRICK_TOP+3*BRICK_H and bh < COLS*BRICK_W; row/col via compare chain, no divider; register idx = row*COLS+col -> CHECK.
REQ-020 CHECK: in_field && arr[idx] -> CLEAR; otherwise -> IDLE with no output change.
REQ-021 CLEAR: arr[idx] <= 0, hit <= 1 for exactly one cycle, hit_idx <= idx, score +1 -> IDLE.
REQ-022 Latency: pos_valid at edge N -> hit high during cycle N+3; the arr bit reads 0 from the same cycle.
REQ-023 pos_valid while busy=1 is ignored and not queued.
REQ-024 new_level has priority in every state: arr <= 24'hFFFFFF, FSM -> IDLE, any in-flight lookup aborted, no hit; score unchanged.
REQ-025 new_level and pos_valid in the same IDLE cycle: the level reload wins and the position is dropped.
REQ-026 score saturates at 1023; no wrap-around.
REQ-027 A ball on a row or column boundary pixel belongs to the lower/right brick; bv = BRICK_TOP+3*BRICK_H and bh = COLS*BRICK_W are out of field.
REQ-028 all_clear is combinational from arr; it updates in the same cycle as the final bit clears.
REQ-029 Capture registers use 11 bits; no arithmetic overflow is permitted for any 11-bit input.

Reset
REQ-030 rst=1 asynchronously forces: arr=24'hFFFFFF, hit=0, hit_idx=0, score=0, busy=0, state=IDLE.
REQ-031 rst asserted mid-lookup discards the lookup; no hit pulse after release.
REQ-032 The first pos_valid is accepted on the first rising edge after rst deasserts.

Verification
REQ-033 After reset, pos_valid with bv=45, bh=85 -> hit at cycle+3, hit_idx=1, arr=24'hFFFFFD, score=1.
REQ-034 Repeat bv=45, bh=85 -> no hit; arr and score unchanged.
REQ-035 Boundary inputs: bv=99, bh=639 -> hit_idx=23; bv=100, bh=0 -> no hit; bv=40, bh=640 -> no hit; bv=39 -> no hit.
REQ-036 Pulse pos_valid during busy -> no second lookup; new_level during CHECK -> arr=24'hFFFFFF, no hit, score retained.
REQ-037 Hit all 24 bricks in sequence -> score=24, all_clear=1 in the cycle of the 24th hit; then new_level -> all_clear=0.
REQ-038 Assert rst in LOCATE -> outputs at reset values immediately; no hit after release.

Source files
------------

// File: rtl/brick_hit_ctrl.sv
// brick_hit_ctrl
//   Collision controller for a 3-row brick wall. When a ball position is
//   strobed in, the controller locates which brick (if any) the position
//   falls on. If that brick is still alive it destroys it, pulses hit and
//   bumps a saturating score.
//
//   Ports
//     clk        system clock, all state changes on its rising edge
//     rst        asynchronous active-high reset
//     pos_valid  one-cycle strobe, bv_pos/bh_pos valid this cycle
//     bv_pos     ball vertical pixel position (11 bits)
//     bh_pos     ball horizontal pixel position (11 bits)
//     new_level  one-cycle pulse, restores every brick
//     arr        brick-alive map, bit row*COLS+col, 1 = present
//     hit        one-cycle pulse when a brick is destroyed
//     hit_idx    index of the last destroyed brick, held between hits
//     busy       high whenever the FSM is outside IDLE
//     score      destroyed-brick count since reset, saturates at 1023
//     all_clear  high when no brick is left (combinational from arr)
//
//   Handshake: pos_valid is only sampled while busy is low. A strobe that
//   arrives while busy is high is dropped, not queued. new_level overrides
//   everything, including a strobe in the same cycle.
module brick_hit_ctrl #(
   parameter int BRICK_W   = 80,
   parameter int BRICK_H   = 20,
   parameter int BRICK_TOP = 40,
   parameter int COLS      = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pos_valid,
   input  logic [10:0] bv_pos,
   input  logic [10:0] bh_pos,
   input  logic        new_level,
   output logic [23:0] arr,
   output logic        hit,
   output logic [4:0]  hit_idx,
   output logic        busy,
   output logic [9:0]  score,
   output logic        all_clear
);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_LOCATE = 2'd1;
   localparam logic [1:0] S_CHECK  = 2'd2;
   localparam logic [1:0] S_CLEAR  = 2'd3;

   // Comparisons run at 12 bits, so the largest 11-bit input can never
   // wrap against a field limit.
   localparam logic [11:0] V_TOP  = 12'(BRICK_TOP);
   localparam logic [11:0] V_ROW1 = 12'(BRICK_TOP + BRICK_H);
   localparam logic [11:0] V_ROW2 = 12'(BRICK_TOP + 2 * BRICK_H);
   localparam logic [11:0] V_END  = 12'(BRICK_TOP + 3 * BRICK_H);
   localparam logic [11:0] H_END  = 12'(COLS * BRICK_W);

   logic [1:0]  state;
   logic [10:0] bv_r;
   logic [10:0] bh_r;
   logic        in_field_r;
   logic [4:0]  idx_r;

   logic [11:0] bv_x;
   logic [11:0] bh_x;
   logic        in_field_n;
   logic [1:0]  row_n;
   logic [4:0]  col_n;
   logic [4:0]  idx_n;

   // Brick lookup by compare chain. Using >= puts a boundary pixel on the
   // lower/right brick.
   always_comb begin
      bv_x       = {1'b0, bv_r};
      bh_x       = {1'b0, bh_r};
      in_field_n = (bv_x >= V_TOP) && (bv_x < V_END) && (bh_x < H_END);
      if (bv_x >= V_ROW2)
         row_n = 2'd2;
      else if (bv_x >= V_ROW1)
         row_n = 2'd1;
      else
         row_n = 2'd0;
      col_n = 5'd0;
      for (int c = 1; c < COLS; c++) begin
         if (bh_x >= 12'(c * BRICK_W))
            col_n = 5'(c);
      end
      idx_n = 5'(int'(row_n) * COLS) + col_n;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         arr        <= 24'hFFFFFF;
         hit        <= 1'b0;
         hit_idx    <= 5'd0;
         score      <= 10'd0;
         bv_r       <= 11'd0;
         bh_r       <= 11'd0;
         in_field_r <= 1'b0;
         idx_r      <= 5'd0;
      end else begin
         hit <= 1'b0;
         if (new_level) begin
            // Reload aborts any lookup in flight; score is kept.
            arr   <= 24'hFFFFFF;
            state <= S_IDLE;
         end else begin
            case (state)
               S_IDLE: begin
                  if (pos_valid) begin
                     bv_r  <= bv_pos;
                     bh_r  <= bh_pos;
                     state <= S_LOCATE;
                  end
               end
               S_LOCATE: begin
                  in_field_r <= in_field_n;
                  idx_r      <= idx_n;
                  state      <= S_CHECK;
               end
               S_CHECK: begin
                  if (in_field_r && arr[idx_r])
                     state <= S_CLEAR;
                  else
                     state <= S_IDLE;
               end
               S_CLEAR: begin
                  arr[idx_r] <= 1'b0;
                  hit        <= 1'b1;
                  hit_idx    <= idx_r;
                  if (score != 10'd1023)
                     score <= score + 10'd1;
                  state <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

   assign busy      = (state != S_IDLE);
   assign all_clear = (arr == 24'd0);

endmodule

// File: tb/tb_brick_hit_ctrl.sv
// Testbench for brick_hit_ctrl: random and directed ball positions are
// scored by a division-based reference model. Expected hit packets are
// queued by the driver and popped by a monitor whenever hit is seen.
module tb_brick_hit_ctrl;

   localparam int BRICK_W   = 80;
   localparam int BRICK_H   = 20;
   localparam int BRICK_TOP = 40;
   localparam int COLS      = 8;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        pos_valid = 1'b0;
   logic [10:0] bv_pos = '0;
   logic [10:0] bh_pos = '0;
   logic        new_level = 1'b0;
   logic [23:0] arr;
   logic        hit;
   logic [4:0]  hit_idx;
   logic        busy;
   logic [9:0]  score;
   logic        all_clear;

   brick_hit_ctrl #(
      .BRICK_W(BRICK_W), .BRICK_H(BRICK_H), .BRICK_TOP(BRICK_TOP), .COLS(COLS)
   ) dut (
      .clk(clk), .rst(rst), .pos_valid(pos_valid), .bv_pos(bv_pos),
      .bh_pos(bh_pos), .new_level(new_level), .arr(arr), .hit(hit),
      .hit_idx(hit_idx), .busy(busy), .score(score), .all_clear(all_clear)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // packet: {cyc[15:0], all_clear, score[9:0], arr[23:0], idx[4:0]}
   logic [55:0] exp_q[$];
   int          total = 0;
   int          passed = 0;

   logic [23:0] model_arr = 24'hFFFFFF;
   int          model_score = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: which brick does a position land on (-1 = none)
   function automatic int model_idx(input int bv, input int bh);
      if (bv < BRICK_TOP || bv >= BRICK_TOP + 3 * BRICK_H || bh >= COLS * BRICK_W)
         return -1;
      return ((bv - BRICK_TOP) / BRICK_H) * COLS + bh / BRICK_W;
   endfunction

   // Applies a position to the model; queues the hit it should produce,
   // visible at the negedge whose cycle count is hit_cyc.
   task automatic model_apply(input int bv, input int bh, input int hit_cyc);
      int idx;
      idx = model_idx(bv, bh);
      if (idx >= 0 && model_arr[idx]) begin
         model_arr[idx] = 1'b0;
         if (model_score < 1023) model_score++;
         exp_q.push_back({16'(hit_cyc), (model_arr == 24'd0), 10'(model_score),
                          model_arr, 5'(idx)});
      end
   endtask

   // driver tasks
   task automatic wait_idle();
      int n = 0;
      while (busy && n < 20) begin @(negedge clk); n++; end
      if (busy) chk("busy_timeout", 32'(busy), 32'd0);
   endtask

   task automatic send(input int bv, input int bh);
      @(negedge clk);
      wait_idle();
      bv_pos = 11'(bv); bh_pos = 11'(bh); pos_valid = 1'b1;
      model_apply(bv, bh, cyc + 4);
      @(negedge clk);
      pos_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic level();
      @(negedge clk);
      new_level = 1'b1;
      model_arr = 24'hFFFFFF;
      @(negedge clk);
      new_level = 1'b0;
   endtask

   task automatic send_brick(input int i);
      send(BRICK_TOP + (i / COLS) * BRICK_H + $urandom_range(0, BRICK_H - 1),
           (i % COLS) * BRICK_W + $urandom_range(0, BRICK_W - 1));
   endtask

   // monitor / scoreboard
   always @(negedge clk) begin
      if (!rst && hit) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_hit", {27'd0, hit_idx}, 32'h0);
         end else begin
            logic [55:0] e;
            e = exp_q.pop_front();
            chk("hit_idx", 32'(hit_idx), 32'(e[4:0]));
            chk("hit_arr", 32'(arr), 32'(e[28:5]));
            chk("hit_score", 32'(score), 32'(e[38:29]));
            chk("hit_all_clear", 32'(all_clear), 32'(e[39]));
            chk("hit_cycle", 32'(cyc), 32'(e[55:40]));
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int order[$];
      repeat (3) @(negedge clk);
      chk("rst_arr", 32'(arr), 32'hFFFFFF);
      chk("rst_hit", 32'(hit), 32'd0);
      chk("rst_hit_idx", 32'(hit_idx), 32'd0);
      chk("rst_score", 32'(score), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_all_clear", 32'(all_clear), 32'd0);
      rst = 1'b0;

      // first strobe right after release, then a repeat on a dead brick
      bv_pos = 11'd45; bh_pos = 11'd85; pos_valid = 1'b1;
      model_apply(45, 85, cyc + 4);
      @(negedge clk); pos_valid = 1'b0;
      repeat (3) @(negedge clk);
      send(45, 85);
      chk("repeat_arr", 32'(arr), 32'hFFFFFD);
      chk("repeat_score", 32'(score), 32'd1);

      // boundaries
      send(99, 639);
      send(100, 0);
      send(40, 640);
      send(39, 100);
      send(2047, 2047);
      send(60, 80);     // boundary pixel -> lower/right brick 9
      chk("bound_arr", 32'(arr), 32'(model_arr));

      // strobe while busy is dropped
      @(negedge clk);
      bv_pos = 11'd50; bh_pos = 11'd410; pos_valid = 1'b1;
      model_apply(50, 410, cyc + 4);
      @(negedge clk);
      bh_pos = 11'd490;
      @(negedge clk);
      pos_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("busy_drop_arr", 32'(arr), 32'(model_arr));

      // new_level sampled while in CHECK aborts the lookup
      @(negedge clk);
      bv_pos = 11'd50; bh_pos = 11'd570; pos_valid = 1'b1;
      @(negedge clk); pos_valid = 1'b0;
      @(negedge clk); new_level = 1'b1;
      @(negedge clk); new_level = 1'b0;
      model_arr = 24'hFFFFFF;
      repeat (4) @(negedge clk);
      chk("nl_check_arr", 32'(arr), 32'hFFFFFF);
      chk("nl_check_score", 32'(score), 32'(model_score));
      chk("nl_check_busy", 32'(busy), 32'd0);

      // new_level and pos_valid together in IDLE
      @(negedge clk);
      bv_pos = 11'd45; bh_pos = 11'd5; pos_valid = 1'b1; new_level = 1'b1;
      @(negedge clk); pos_valid = 1'b0; new_level = 1'b0;
      repeat (4) @(negedge clk);
      chk("nl_same_cycle_arr", 32'(arr), 32'hFFFFFF);

      // random positions
      repeat (40) send($urandom_range(30, 110), $urandom_range(0, 700));

      // clear the whole wall in random order
      level();
      order.delete();
      for (int i = 0; i < 24; i++) order.push_back(i);
      order.shuffle();
      foreach (order[i]) send_brick(order[i]);
      chk("clear_all_clear", 32'(all_clear), 32'd1);
      chk("clear_score", 32'(score), 32'(model_score));
      level();
      @(negedge clk);
      chk("reload_all_clear", 32'(all_clear), 32'd0);

      // reset while in LOCATE
      @(negedge clk);
      bv_pos = 11'd45; bh_pos = 11'd5; pos_valid = 1'b1;
      @(negedge clk); pos_valid = 1'b0;
      #1 rst = 1'b1;
      #1;
      chk("rst_mid_arr", 32'(arr), 32'hFFFFFF);
      chk("rst_mid_score", 32'(score), 32'd0);
      chk("rst_mid_busy", 32'(busy), 32'd0);
      chk("rst_mid_hit_idx", 32'(hit_idx), 32'd0);
      model_arr = 24'hFFFFFF;
      model_score = 0;
      @(negedge clk); rst = 1'b0;
      repeat (6) @(negedge clk);

      // score saturation: 43 walls = 1032 hits
      for (int r = 0; r < 43; r++) begin
         level();
         for (int i = 0; i < 24; i++) send_brick(i);
      end
      chk("sat_score", 32'(score), 32'd1023);

      begin
         int n = 0;
         while (exp_q.size() != 0 && n < 20) begin @(negedge clk); n++; end
      end
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
